// File: rtl/uart_tx_fifo_param_if.sv
// Producer-side valid/ready handshake for the FIFO-fed UART transmitter.
// The producer drives the master side; the transmitter is the slave.
interface uart_tx_fifo_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with an input FIFO.
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_fifo_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_param_if.slave         tx,
  output logic                        UART_Tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int CPB       = CLK_FREQ / BAUD;
  localparam int STOP_CLKS = STOP_BITS * CPB;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int BW        = $clog2(STOP_CLKS + 1);
  localparam int IW        = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [BW-1:0]        baud;
  logic [IW-1:0]        bit_idx;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 stop_end;
  logic                 active_nxt;
  logic [AW:0]          count_nxt;

  assign full      = fifo_count == (AW+1)'(FIFO_DEPTH);
  assign empty     = fifo_count == '0;
  assign push      = tx.tx_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign bit_end   = baud == BW'(CPB - 1);
  assign stop_end  = baud == BW'(STOP_CLKS - 1);
  assign count_nxt = fifo_count + (AW+1)'(push)
                   - (AW+1)'(pop);

  assign tx.tx_ready = !full;

  // FSM leaves IDLE only on a pop and returns only at the end of STOP
  assign active_nxt = (state == IDLE) ? pop
                    : !((state == STOP) && stop_end);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx.tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      UART_Tx <= 1'b1;
      busy    <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      busy <= active_nxt || (count_nxt != '0);
      unique case (state)
        IDLE: begin
          UART_Tx <= 1'b1;
          baud    <= '0;
          if (pop) begin
            shreg   <= mem[rd_ptr];
            par_bit <= (PARITY == 1) ? ~^mem[rd_ptr]
                                     : ^mem[rd_ptr];
            UART_Tx <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            UART_Tx <= shreg[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud  <= '0;
            shreg <= shreg >> 1;
            if (bit_idx == IW'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                UART_Tx <= par_bit;
                state   <= PAR;
              end else begin
                UART_Tx <= 1'b1;
                state   <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              UART_Tx <= shreg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        PAR: begin
          if (bit_end) begin
            baud    <= '0;
            UART_Tx <= 1'b1;
            state   <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (stop_end) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          UART_Tx <= 1'b1;
          baud    <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: frame vectors on four configurations,
// plus a serial receiver model checking every 8N1 frame against a queue.
module tb_uart_tx_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [8:0] din [4];
  logic       vin [4];
  logic       rdy [4];
  logic       line [4];
  logic       bsy [4];
  logic [4:0] cnt [4];

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_fifo_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_fifo_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_fifo_param_if #(.DATA_BITS(9)) if3 ();

  assign if0.tx_data = din[0][7:0];
  assign if1.tx_data = din[1][7:0];
  assign if2.tx_data = din[2][7:0];
  assign if3.tx_data = din[3];
  assign if0.tx_valid = vin[0];
  assign if1.tx_valid = vin[1];
  assign if2.tx_valid = vin[2];
  assign if3.tx_valid = vin[3];
  assign rdy[0] = if0.tx_ready;
  assign rdy[1] = if1.tx_ready;
  assign rdy[2] = if2.tx_ready;
  assign rdy[3] = if3.tx_ready;

  uart_tx_fifo_param #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u0 (
    .clk(clk), .rst(rst), .tx(if0.slave), .UART_Tx(line[0]),
    .busy(bsy[0]), .fifo_count(cnt[0])
  );

  uart_tx_fifo_param #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u1 (
    .clk(clk), .rst(rst), .tx(if1.slave), .UART_Tx(line[1]),
    .busy(bsy[1]), .fifo_count(cnt[1])
  );

  uart_tx_fifo_param #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u2 (
    .clk(clk), .rst(rst), .tx(if2.slave), .UART_Tx(line[2]),
    .busy(bsy[2]), .fifo_count(cnt[2])
  );

  uart_tx_fifo_param #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(9),
    .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) u3 (
    .clk(clk), .rst(rst), .tx(if3.slave), .UART_Tx(line[3]),
    .busy(bsy[3]), .fifo_count(cnt[3])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or model empty", nm);
  endtask

  // Reference receiver for instance 0 (8N1, 10 clk/bit)
  logic [7:0] exp_q [$];
  int         falls [$];
  int         ncyc = 0;
  bit         m_act = 0;
  int         m_cnt = 0;
  logic [7:0] m_word;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      m_act = 0;
    end else if (!m_act) begin
      if (line[0] == 1'b0) begin
        m_act = 1;
        m_cnt = 0;
        falls.push_back(ncyc);
      end
    end else begin
      m_cnt++;
      if (m_cnt == 5) chk("rx_start", 32'(line[0]), 0);
      for (int i = 0; i < 8; i++)
        if (m_cnt == 15 + 10 * i) m_word[i] = line[0];
      if (m_cnt == 95) begin
        chk("rx_stop", 32'(line[0]), 1);
        if (exp_q.size() == 0) fail_now("rx_unexpected_frame");
        else chk("rx_word", 32'(m_word), 32'(exp_q.pop_front()));
        m_act = 0;
      end
    end
  end

  task automatic push0(input logic [7:0] d);
    int w;
    w = 0;
    @(negedge clk);
    din[0] = {1'b0, d};
    vin[0] = 1'b1;
    while (!rdy[0] && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) fail_now("push_timeout");
    @(posedge clk);
    exp_q.push_back(d);
  endtask

  task automatic wait_idle(input int lim);
    int w;
    w = 0;
    @(negedge clk);
    while ((bsy[0] || bsy[1] || bsy[2] || bsy[3]) && w < lim) begin
      @(negedge clk);
      w++;
    end
    if (w >= lim) fail_now("idle_timeout");
  endtask

  typedef struct {
    int          k;
    logic [8:0]  data;
    logic [11:0] frame;
    int          slots;
    int          len;
  } vec_t;

  vec_t vt [5];

  initial begin
    int n;
    int lows;
    int w;
    vt[0] = '{0, 9'h0A5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 100};
    vt[1] = '{0, 9'h03C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 100};
    vt[2] = '{1, 9'h007, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 110};
    vt[3] = '{2, 9'h007, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 110};
    vt[4] = '{3, 9'h1FF, {2'b11, 9'h1FF, 1'b0}, 12, 120};

    for (int k = 0; k < 4; k++) begin
      din[k] = '0;
      vin[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_line", 32'(line[0]), 1);
    chk("rst_ready", 32'(rdy[0]), 1);
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_count", 32'(cnt[0]), 0);
    chk("rst_line3", 32'(line[3]), 1);

    // Frame vectors: latency, every bit slot, frame length via busy
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      din[vt[v].k] = vt[v].data;
      vin[vt[v].k] = 1'b1;
      if (vt[v].k == 0) exp_q.push_back(vt[v].data[7:0]);
      @(negedge clk);
      vin[vt[v].k] = 1'b0;
      chk("lat_high", 32'(line[vt[v].k]), 1);
      @(negedge clk);
      chk("lat_low", 32'(line[vt[v].k]), 0);
      n = 0;
      for (int i = 0; i < vt[v].slots; i++) begin
        while (n < 10 * i + 5) begin
          @(negedge clk);
          n++;
        end
        chk($sformatf("v%0d_slot%0d", v, i),
            32'(line[vt[v].k]), 32'(vt[v].frame[i]));
      end
      while (n < vt[v].len - 1) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d_busy_end", v), 32'(bsy[vt[v].k]), 1);
      @(negedge clk);
      chk($sformatf("v%0d_busy_done", v), 32'(bsy[vt[v].k]), 0);
      repeat (3) @(negedge clk);
    end

    // FIFO fill: 17 accepted back-to-back, an 18th waits on full
    falls.delete();
    for (int i = 0; i < 17; i++) push0(8'(i));
    @(negedge clk);
    chk("t3_count_full", 32'(cnt[0]), 16);
    chk("t3_ready_low", 32'(rdy[0]), 0);
    din[0] = 9'h011;
    repeat (20) @(negedge clk);
    chk("t3_push_ignored", 32'(cnt[0]), 16);
    push0(8'h11);
    @(negedge clk);
    vin[0] = 1'b0;
    wait_idle(3000);
    chk("t3_all_received", 32'(exp_q.size()), 0);
    chk("t3_frames", 32'(falls.size()), 18);
    for (int i = 1; i < falls.size(); i++)
      chk($sformatf("t3_gap%0d", i), 32'(falls[i] - falls[i-1]), 101);

    // Random words with random gaps
    for (int i = 0; i < 24; i++) begin
      push0(8'($urandom));
      @(negedge clk);
      vin[0] = 1'b0;
      repeat ($urandom_range(0, 150)) @(negedge clk);
    end
    wait_idle(4000);
    chk("rand_all_received", 32'(exp_q.size()), 0);

    // Reset during the 4th data bit with three words queued
    push0(8'h55);
    push0(8'h66);
    push0(8'h77);
    push0(8'h88);
    @(negedge clk);
    vin[0] = 1'b0;
    w = 0;
    while (line[0] !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) fail_now("t4_no_start");
    repeat (45) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t4_line", 32'(line[0]), 1);
    chk("t4_count", 32'(cnt[0]), 0);
    chk("t4_busy", 32'(bsy[0]), 0);
    chk("t4_ready", 32'(rdy[0]), 1);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (line[0] !== 1'b1) lows++;
    end
    chk("t4_no_restart", 32'(lows), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
